// File: rtl/capture_buffer.sv
// Circular acquisition memory: once armed it keeps PRE samples ahead of the
// trigger sample, fills the rest of the record after it, then freezes for readout.
module capture_buffer #(
    parameter int DW  = 12,
    parameter int AW  = 10,
    parameter int PRE = 256
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          sample_valid_i,
    input  logic [DW-1:0] sample_i,
    input  logic          trig_i,
    input  logic          arm_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o,
    output logic          busy_o,
    output logic          done_o
);

    localparam int DEPTH = 1 << AW;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PREFILL = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_POST    = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    // Terminal counts are compared before the increment, hence the -1 / -2.
    localparam logic [AW-1:0] ONE       = AW'(1);
    localparam logic [AW-1:0] PRE_OFF   = AW'(PRE);
    localparam logic [AW-1:0] PRE_LAST  = AW'((PRE == 0) ? 0 : PRE - 1);
    localparam logic [AW-1:0] POST_LAST = AW'((PRE >= DEPTH - 1) ? 0 : DEPTH - PRE - 2);
    localparam logic [2:0]    ARM_NEXT  = (PRE == 0) ? S_WAIT : S_PREFILL;
    localparam logic [2:0]    TRIG_NEXT = (PRE == DEPTH - 1) ? S_DONE : S_POST;

    logic [DW-1:0] mem [DEPTH];

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] start_ptr_q, start_ptr_d;
    logic [DW-1:0] rd_data_q;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          wr_en;
    logic [AW-1:0] rd_idx;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        start_ptr_d = start_ptr_q;
        wr_en       = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (arm_i) begin
                    wr_ptr_d = '0;
                    cnt_d    = '0;
                    state_d  = ARM_NEXT;
                end
            end
            S_PREFILL: begin
                if (sample_valid_i) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + ONE;
                    if (cnt_q == PRE_LAST) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (sample_valid_i) begin
                    wr_en = 1'b1;
                    if (trig_i) begin
                        // Oldest kept sample sits PRE slots behind the trigger slot.
                        start_ptr_d = wr_ptr_q - PRE_OFF;
                        cnt_d       = '0;
                        state_d     = TRIG_NEXT;
                    end
                end
            end
            S_POST: begin
                if (sample_valid_i) begin
                    wr_en = 1'b1;
                    cnt_d = cnt_q + ONE;
                    if (cnt_q == POST_LAST) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + ONE;
        end
    end

    always_comb begin
        busy_d = (state_d == S_PREFILL) || (state_d == S_WAIT) || (state_d == S_POST);
        done_d = (state_d == S_DONE);
        rd_idx = start_ptr_q + rd_addr_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            start_ptr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            start_ptr_q <= start_ptr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Storage is left unreset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= sample_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= mem[rd_idx];
        end
    end

    assign rd_data_o = rd_data_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_capture_buffer.sv
// Bench for capture_buffer (DW=8, AW=4, PRE=4): table of capture scenarios plus
// hand-written reset-abort and re-arm sequences; readback checked via a queue.
module tb_capture_buffer;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int PRE = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sample_valid_i = 1'b0;
    logic [DW-1:0] sample_i = '0;
    logic          trig_i = 1'b0;
    logic          arm_i = 1'b0;
    logic [AW-1:0] rd_addr_i = '0;
    logic [DW-1:0] rd_data_o;
    logic          busy_o;
    logic          done_o;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];

    typedef struct {
        int trig_at;
        bit toggle;
        bit early;
        int arm_at;
        int exp_first;
    } vec_t;

    vec_t tbl[6];

    capture_buffer #(.DW(DW), .AW(AW), .PRE(PRE)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .trig_i         (trig_i),
        .arm_i          (arm_i),
        .rd_addr_i      (rd_addr_i),
        .rd_data_o      (rd_data_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic readback(input string tag, input int first);
        int got_exp;
        for (int a = 0; a < 16; a++) begin
            rd_addr_i = a[AW-1:0];
            exp_q.push_back(int'(8'(first + a)));
            step();
            got_exp = exp_q.pop_front();
            check($sformatf("%s rd[%0d]", tag, a), int'(rd_data_o), got_exp);
        end
    endtask

    // Arms, streams a ramp until done (bounded), then reads the record back.
    task automatic capture(input string tag, input vec_t v);
        int s;
        int cyc;
        arm_i = 1'b1;
        sample_valid_i = 1'b0;
        trig_i = 1'b0;
        step();
        arm_i = 1'b0;
        check({tag, " busy_after_arm"}, int'(busy_o), 1);
        s = 0;
        cyc = 0;
        while (!done_o && cyc < 400) begin
            if (v.toggle && (cyc % 2 == 1)) begin
                sample_valid_i = 1'b0;
                trig_i = 1'b1;
                arm_i = 1'b0;
            end else begin
                sample_valid_i = 1'b1;
                sample_i = 8'(s);
                trig_i = (s == v.trig_at) || (v.early && (s == 2 || s == 3));
                arm_i = (v.arm_at >= 0) && (s == v.arm_at);
                s++;
            end
            step();
            cyc++;
        end
        sample_valid_i = 1'b0;
        trig_i = 1'b0;
        arm_i = 1'b0;
        check({tag, " done"}, int'(done_o), 1);
        check({tag, " samples_to_done"}, s, v.trig_at + 12);
        check({tag, " busy_when_done"}, int'(busy_o), 0);
        readback(tag, v.exp_first);
    endtask

    initial begin
        //          trig toggle early arm_at first
        tbl[0] = '{10, 1'b0, 1'b0, -1,  6};
        tbl[1] = '{ 7, 1'b0, 1'b1, -1,  3};
        tbl[2] = '{ 9, 1'b1, 1'b0, -1,  5};
        tbl[3] = '{40, 1'b0, 1'b0, -1, 36};
        tbl[4] = '{ 6, 1'b0, 1'b0,  2,  2};
        tbl[5] = '{12, 1'b0, 1'b0, 14,  8};

        rst_n = 1'b0;
        step();
        step();
        check("reset busy", int'(busy_o), 0);
        check("reset done", int'(done_o), 0);
        check("reset rd_data", int'(rd_data_o), 0);
        #2 rst_n = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            capture($sformatf("case%0d", i + 1), tbl[i]);
        end

        // Reset in the middle of POST aborts the capture immediately.
        arm_i = 1'b1;
        step();
        arm_i = 1'b0;
        for (int s = 0; s < 14; s++) begin
            sample_valid_i = 1'b1;
            sample_i = 8'(100 + s);
            trig_i = (s == 10);
            step();
        end
        sample_valid_i = 1'b0;
        trig_i = 1'b0;
        check("post busy_before_rst", int'(busy_o), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst busy", int'(busy_o), 0);
        check("rst done", int'(done_o), 0);
        check("rst rd_data", int'(rd_data_o), 0);
        #2 rst_n = 1'b1;
        step();
        check("rst stays_idle", int'(busy_o), 0);
        capture("case5", '{8, 1'b0, 1'b0, -1, 4});

        // Re-arm from DONE alongside a read: the read still sees the old record.
        rd_addr_i = 4'd3;
        arm_i = 1'b1;
        step();
        arm_i = 1'b0;
        check("rearm rd_old", int'(rd_data_o), 7);
        check("rearm done", int'(done_o), 0);
        check("rearm busy", int'(busy_o), 1);

        // Arms arriving while busy (PREFILL, then POST) must be ignored.
        capture("case6a", tbl[4]);
        capture("case6b", tbl[5]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
